cva6_dport_arbiter: RTL and testbench
=====================================

Name: cva6_dport_arbiter

Overview:
- Round-robin arbiter that shares one OBI-style data memory port between NR_PORTS requesters (load unit, store unit, CVXIF memory path).
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to the requester that issued it.
- Sits between the load/store units and the data cache port. XLEN and data-user width come from the core configuration package.

Parameters:
- NR_PORTS, 3, number of requesters (2..8)
- XLEN, 64, data width
- ADDR_WIDTH, 64, address width
- DATA_USER_WIDTH, 64, width of write/read user sideband
- MAX_OUTSTANDING, 4, ID FIFO depth (power of two, >=2)

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  synchronous active-low reset
- req_i  in  NR_PORTS  per-port request
- addr_i  in  NR_PORTS x ADDR_WIDTH  per-port address
- we_i  in  NR_PORTS  per-port write enable
- be_i  in  NR_PORTS x XLEN/8  per-port byte enables
- wdata_i  in  NR_PORTS x XLEN  per-port write data
- wuser_i  in  NR_PORTS x DATA_USER_WIDTH  per-port write user
- gnt_o  out  NR_PORTS  per-port grant
- rvalid_o  out  NR_PORTS  per-port response valid
- rdata_o  out  XLEN  shared response data
- ruser_o  out  DATA_USER_WIDTH  shared response user
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  XLEN/8  memory byte enables
- mem_wdata_o  out  XLEN  memory write data
- mem_wuser_o  out  DATA_USER_WIDTH  memory write user
- mem_rvalid_i  in  1  memory response valid (reads and writes)
- mem_rdata_i  in  XLEN  memory read data
- mem_ruser_i  in  DATA_USER_WIDTH  memory read user
- err_o  out  1  sticky protocol error

Behaviour:
- Single clock clk_i. Reset rst_ni is synchronous and active-low.
- Reset state: rr_ptr=0, FSM=IDLE, FIFO empty, err_o=0, lock index=0. All outputs are 0 under reset.
- Arbitration: combinational round-robin starting at rr_ptr. The lowest index >= rr_ptr with req_i set wins, wrapping modulo NR_PORTS.
- FSM IDLE:
  - If any req_i is set and the FIFO is not full, drive mem_* from the winner, mem_req_o=1, same cycle (zero latency).
  - Grant in the same cycle: return to IDLE.
  - No grant: go to HOLD and latch the winner index.
- FSM HOLD: mem_req_o=1 and mem_* are driven from the latched index; no re-arbitration. A requester must hold req_i and its payload stable until gnt_o (OBI rule). On mem_gnt_i, return to IDLE.
- gnt_o[i] = mem_req_o & mem_gnt_i & (selected index == i).
- On each grant handshake:
  - rr_ptr <= (granted index + 1) mod NR_PORTS.
  - The granted index is pushed into the ID FIFO.
- FIFO full in IDLE: mem_req_o=0 and no grant, even if mem_rvalid_i pops in the same cycle. The request starts the next cycle.
- Response path:
  - On mem_rvalid_i, pop the FIFO head. rvalid_o[head]=1 combinationally, all other rvalid_o bits are 0.
  - rdata_o = mem_rdata_i, unqualified.
- Push and pop in the same cycle when the FIFO is not full: count is unchanged and order is preserved.
- mem_rvalid_i with the FIFO empty: response dropped, no rvalid_o, err_o set to 1. err_o clears only on reset.
- Reset mid-transaction: the FIFO is flushed and HOLD is abandoned. In-flight responses after reset set err_o.

Optional Feature:
- Macro: CVA6_DATA_USER_EN
- Defined: mem_wuser_o comes from the selected wuser_i, and ruser_o = mem_ruser_i.
- Undefined: mem_wuser_o=0 and ruser_o=0. User inputs are ignored. Ports remain present.

Decomposition:
- Shared package cva6_dport_pkg holds:
  - typedef dport_idx_t: logic [$clog2(NR_PORTS)-1:0]
  - packed struct dport_req_t {addr, we, be, wdata, wuser}
  - FSM enum {IDLE, HOLD}
- One sub-module: cva6_dport_id_fifo, a MAX_OUTSTANDING-deep FIFO of dport_idx_t with push, pop, full, empty and head.

Test Plan:
- Single requester: port 1 issues a read to 0x8000_0040 with mem_gnt_i=1 → gnt_o=3'b010 the same cycle. mem_rvalid_i two cycles later with rdata 0xDEAD_BEEF → rvalid_o=3'b010, rdata_o=0xDEAD_BEEF.
- Fairness: all three req_i held high, gnt always 1 → grant order 0,1,2,0,1,2 over 6 cycles.
- HOLD stability: port 0 requests with mem_gnt_i=0 for 3 cycles while port 2 raises req → mem_addr_o stays port 0's address, and the first grant goes to port 0.
- Full FIFO: 4 grants with no responses, then a 5th request → mem_req_o=0. mem_rvalid_i pops in the same cycle but mem_req_o stays 0. Next cycle mem_req_o=1.
- Ordering: grants to ports 2,0,1, then 3 responses → rvalid_o sequence 3'b100, 3'b001, 3'b010.
- Error: mem_rvalid_i=1 with the FIFO empty → rvalid_o=0 and err_o=1, held until rst_ni=0 for one clock edge.

Source files
------------

// File: rtl/cva6_dport_pkg.sv
// Shared configuration and types for the CVA6 data-port arbiter.
// The widths below are the core configuration; all arbiter files import them.
package cva6_dport_pkg;

  localparam int unsigned NR_PORTS        = 3;
  localparam int unsigned XLEN            = 64;
  localparam int unsigned ADDR_WIDTH      = 64;
  localparam int unsigned DATA_USER_WIDTH = 64;
  localparam int unsigned MAX_OUTSTANDING = 4;
  localparam int unsigned IDX_W           = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  typedef logic [IDX_W-1:0] dport_idx_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      addr;
    logic                       we;
    logic [XLEN/8-1:0]          be;
    logic [XLEN-1:0]            wdata;
    logic [DATA_USER_WIDTH-1:0] wuser;
  } dport_req_t;

  typedef enum logic {IDLE, HOLD} dport_state_e;

  function automatic dport_idx_t next_idx(input dport_idx_t i);
    return (i == dport_idx_t'(NR_PORTS - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/cva6_dport_arbiter_if.sv
// Requester-side and memory-side bundles of the data-port arbiter.
// Member names carry the arbiter's own _i/_o direction.
interface cva6_dport_req_if;
  import cva6_dport_pkg::*;

  logic [NR_PORTS-1:0]                      req_i;
  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]      addr_i;
  logic [NR_PORTS-1:0]                      we_i;
  logic [NR_PORTS-1:0][XLEN/8-1:0]          be_i;
  logic [NR_PORTS-1:0][XLEN-1:0]            wdata_i;
  logic [NR_PORTS-1:0][DATA_USER_WIDTH-1:0] wuser_i;
  logic [NR_PORTS-1:0]                      gnt_o;
  logic [NR_PORTS-1:0]                      rvalid_o;
  logic [XLEN-1:0]                          rdata_o;
  logic [DATA_USER_WIDTH-1:0]               ruser_o;

  modport master (output req_i, addr_i, we_i, be_i, wdata_i, wuser_i,
                  input  gnt_o, rvalid_o, rdata_o, ruser_o);
  modport slave  (input  req_i, addr_i, we_i, be_i, wdata_i, wuser_i,
                  output gnt_o, rvalid_o, rdata_o, ruser_o);
endinterface

interface cva6_dport_mem_if;
  import cva6_dport_pkg::*;

  logic                       mem_req_o;
  logic                       mem_gnt_i;
  logic [ADDR_WIDTH-1:0]      mem_addr_o;
  logic                       mem_we_o;
  logic [XLEN/8-1:0]          mem_be_o;
  logic [XLEN-1:0]            mem_wdata_o;
  logic [DATA_USER_WIDTH-1:0] mem_wuser_o;
  logic                       mem_rvalid_i;
  logic [XLEN-1:0]            mem_rdata_i;
  logic [DATA_USER_WIDTH-1:0] mem_ruser_i;

  modport master (output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, mem_wuser_o,
                  input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_ruser_i);
  modport slave  (input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, mem_wuser_o,
                  output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_ruser_i);
endinterface

// File: rtl/cva6_dport_id_fifo.sv
// In-order FIFO of requester indices for outstanding memory transactions.
// Push while full and pop while empty are ignored; head is valid when not empty.
module cva6_dport_id_fifo
  import cva6_dport_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  dport_idx_t data_i,
  input  logic       pop_i,
  output dport_idx_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

  dport_idx_t [MAX_OUTSTANDING-1:0] mem_q;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PTR_W+1)'(MAX_OUTSTANDING));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cva6_dport_arbiter.sv
// Round-robin arbiter sharing one OBI data port; responses routed back in issue order.
// CVA6_DATA_USER_EN passes the write/read user sideband through; otherwise it reads as zero.
module cva6_dport_arbiter
  import cva6_dport_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  cva6_dport_req_if.slave  port_if,
  cva6_dport_mem_if.master mem_if,
  output logic             err_o
);

  localparam int NP = int'(NR_PORTS);

  dport_state_e        state_q, state_d;
  dport_idx_t          rr_ptr_q, rr_ptr_d, lock_q, lock_d;
  dport_idx_t          winner, cand, sel, head;
  logic                err_q, err_d;
  logic                mem_req, push, fifo_pop, fifo_full, fifo_empty;
  logic [NR_PORTS-1:0] gnt, rvalid;
  dport_req_t          sel_req;

  // Scan downwards so the lowest offset from rr_ptr_q is the last assignment.
  always_comb begin
    winner = rr_ptr_q;
    cand   = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      cand = dport_idx_t'((int'(rr_ptr_q) + i) % NP);
      if (port_if.req_i[cand]) winner = cand;
    end
  end

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    mem_req  = 1'b0;
    sel      = winner;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          if (|port_if.req_i && !fifo_full) begin
            mem_req = 1'b1;
            if (!mem_if.mem_gnt_i) begin
              state_d = HOLD;
              lock_d  = winner;
            end
          end
        end
        HOLD: begin
          mem_req = 1'b1;
          sel     = lock_q;
          if (mem_if.mem_gnt_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    push = mem_req & mem_if.mem_gnt_i;
    if (push) rr_ptr_d = next_idx(sel);
    fifo_pop = rst_ni & mem_if.mem_rvalid_i & ~fifo_empty;
    if (rst_ni & mem_if.mem_rvalid_i & fifo_empty) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      lock_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  cva6_dport_id_fifo i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (sel),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    sel_req.addr  = port_if.addr_i[sel];
    sel_req.we    = port_if.we_i[sel];
    sel_req.be    = port_if.be_i[sel];
    sel_req.wdata = port_if.wdata_i[sel];
`ifdef CVA6_DATA_USER_EN
    sel_req.wuser = port_if.wuser_i[sel];
`else
    sel_req.wuser = '0;
`endif
    gnt    = '0;
    rvalid = '0;
    if (push)     gnt[sel]     = 1'b1;
    if (fifo_pop) rvalid[head] = 1'b1;
  end

  assign mem_if.mem_req_o   = mem_req;
  assign mem_if.mem_addr_o  = mem_req ? sel_req.addr  : '0;
  assign mem_if.mem_we_o    = mem_req & sel_req.we;
  assign mem_if.mem_be_o    = mem_req ? sel_req.be    : '0;
  assign mem_if.mem_wdata_o = mem_req ? sel_req.wdata : '0;
  assign mem_if.mem_wuser_o = mem_req ? sel_req.wuser : '0;

  assign port_if.gnt_o    = gnt;
  assign port_if.rvalid_o = rvalid;
  assign port_if.rdata_o  = rst_ni ? mem_if.mem_rdata_i : '0;
`ifdef CVA6_DATA_USER_EN
  assign port_if.ruser_o  = rst_ni ? mem_if.mem_ruser_i : '0;
`else
  assign port_if.ruser_o  = '0;
  logic unused_user;
  assign unused_user = ^{port_if.wuser_i, mem_if.mem_ruser_i};
`endif
  assign err_o = err_q & rst_ni;

endmodule

// File: tb/tb_cva6_dport_arbiter.sv
// Directed bench for cva6_dport_arbiter; responses are checked against a queue of expected grants.
module tb_cva6_dport_arbiter;
  import cva6_dport_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic err_o;
  int   n_pass  = 0;
  int   n_total = 0;
  dport_idx_t sb_q[$];

  cva6_dport_req_if port_if ();
  cva6_dport_mem_if mem_if ();

  cva6_dport_arbiter dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .port_if (port_if),
    .mem_if  (mem_if),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_gnt(input string tag, input dport_idx_t p);
    logic [NR_PORTS-1:0] e;
    e    = '0;
    e[p] = 1'b1;
    check(tag, 64'(port_if.gnt_o), 64'(e));
    sb_q.push_back(p);
  endtask

  task automatic expect_resp(input string tag);
    logic [NR_PORTS-1:0] e;
    e = '0;
    if (sb_q.size() != 0) e[sb_q.pop_front()] = 1'b1;
    check(tag, 64'(port_if.rvalid_o), 64'(e));
  endtask

  task automatic drive_idle();
    port_if.req_i       = '0;
    mem_if.mem_gnt_i    = 1'b0;
    mem_if.mem_rvalid_i = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_wuser;
    rst_ni               = 1'b0;
    port_if.req_i        = 3'b111;
    port_if.addr_i       = '0;
    port_if.we_i         = '0;
    port_if.be_i         = '0;
    port_if.wdata_i      = '0;
    port_if.wuser_i      = '0;
    mem_if.mem_gnt_i     = 1'b1;
    mem_if.mem_rvalid_i  = 1'b1;
    mem_if.mem_rdata_i   = 64'h1234;
    mem_if.mem_ruser_i   = 64'h55;

    // Reset: everything quiet regardless of inputs
    #1;
    check("rst_mem_req", 64'(mem_if.mem_req_o), 64'd0);
    check("rst_gnt", 64'(port_if.gnt_o), 64'd0);
    check("rst_rvalid", 64'(port_if.rvalid_o), 64'd0);
    check("rst_rdata", port_if.rdata_o, 64'd0);
    tick();
    tick();
    check("rst_err", 64'(err_o), 64'd0);
    drive_idle();
    rst_ni = 1'b1;
    #1;
    check("idle_mem_req", 64'(mem_if.mem_req_o), 64'd0);
    tick();

    // Single requester read, response two cycles later
    port_if.req_i     = 3'b010;
    port_if.addr_i[1] = 64'h8000_0040;
    mem_if.mem_gnt_i  = 1'b1;
    #1;
    check("single_mem_req", 64'(mem_if.mem_req_o), 64'd1);
    check("single_addr", mem_if.mem_addr_o, 64'h8000_0040);
    check("single_we", 64'(mem_if.mem_we_o), 64'd0);
    expect_gnt("single_gnt", dport_idx_t'(1));
    tick();
    drive_idle();
    tick();
    mem_if.mem_rvalid_i = 1'b1;
    mem_if.mem_rdata_i  = 64'hDEAD_BEEF;
    #1;
    expect_resp("single_rvalid");
    check("single_rdata", port_if.rdata_o, 64'hDEAD_BEEF);
    tick();
    drive_idle();

    // Fairness from a fresh pointer, with a response every cycle after the first
    rst_ni = 1'b0;
    tick();
    rst_ni           = 1'b1;
    port_if.req_i    = 3'b111;
    mem_if.mem_gnt_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      mem_if.mem_rvalid_i = (c != 0);
      mem_if.mem_rdata_i  = 64'h100 + 64'(c);
      #1;
      if (c != 0) begin
        expect_resp("fair_rvalid");
        check("fair_rdata", port_if.rdata_o, 64'h100 + 64'(c));
      end
      expect_gnt("fair_gnt", dport_idx_t'(c % 3));
      tick();
    end
    port_if.req_i       = '0;
    mem_if.mem_rvalid_i = 1'b1;
    #1;
    expect_resp("fair_drain");
    tick();
    drive_idle();

    // HOLD: pointer is 1, port 0 wins and must keep the bus while port 2 joins
    port_if.req_i     = 3'b001;
    port_if.addr_i[0] = 64'hA000_0000;
    port_if.addr_i[2] = 64'hB000_0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hold_mem_req", 64'(mem_if.mem_req_o), 64'd1);
      check("hold_addr", mem_if.mem_addr_o, 64'hA000_0000);
      check("hold_no_gnt", 64'(port_if.gnt_o), 64'd0);
      tick();
      port_if.req_i = 3'b101;
    end
    mem_if.mem_gnt_i = 1'b1;
    #1;
    check("hold_addr_gnt", mem_if.mem_addr_o, 64'hA000_0000);
    expect_gnt("hold_gnt0", dport_idx_t'(0));
    tick();
    port_if.req_i = 3'b100;
    #1;
    check("hold_addr2", mem_if.mem_addr_o, 64'hB000_0000);
    expect_gnt("hold_gnt2", dport_idx_t'(2));
    tick();
    drive_idle();
    mem_if.mem_rvalid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      expect_resp("hold_rvalid");
      tick();
    end
    drive_idle();

    // Full FIFO blocks the fifth request even with a same-cycle pop
    port_if.req_i    = 3'b001;
    mem_if.mem_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      expect_gnt("full_fill_gnt", dport_idx_t'(0));
      tick();
    end
    mem_if.mem_rvalid_i = 1'b1;
    #1;
    check("full_mem_req", 64'(mem_if.mem_req_o), 64'd0);
    check("full_gnt", 64'(port_if.gnt_o), 64'd0);
    expect_resp("full_pop");
    tick();
    mem_if.mem_rvalid_i = 1'b0;
    #1;
    check("full_resume_req", 64'(mem_if.mem_req_o), 64'd1);
    expect_gnt("full_resume_gnt", dport_idx_t'(0));
    tick();
    drive_idle();
    mem_if.mem_rvalid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      expect_resp("full_drain");
      tick();
    end
    drive_idle();

    // Ordering 2,0,1 with a write payload on port 0
    port_if.we_i[0]    = 1'b1;
    port_if.be_i[0]    = 8'h0F;
    port_if.wdata_i[0] = 64'hCAFE_F00D_1234_5678;
    port_if.wuser_i[0] = 64'h77;
`ifdef CVA6_DATA_USER_EN
    exp_wuser = 64'h77;
`else
    exp_wuser = 64'h0;
`endif
    mem_if.mem_gnt_i = 1'b1;
    port_if.req_i    = 3'b100;
    #1;
    expect_gnt("ord_gnt2", dport_idx_t'(2));
    tick();
    port_if.req_i = 3'b001;
    #1;
    expect_gnt("ord_gnt0", dport_idx_t'(0));
    check("ord_we", 64'(mem_if.mem_we_o), 64'd1);
    check("ord_be", 64'(mem_if.mem_be_o), 64'h0F);
    check("ord_wdata", mem_if.mem_wdata_o, 64'hCAFE_F00D_1234_5678);
    check("ord_wuser", mem_if.mem_wuser_o, exp_wuser);
    tick();
    port_if.req_i = 3'b010;
    #1;
    expect_gnt("ord_gnt1", dport_idx_t'(1));
    tick();
    drive_idle();
    mem_if.mem_rvalid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      expect_resp("ord_rvalid");
      tick();
    end
    drive_idle();

    // Response with nothing outstanding
    mem_if.mem_rvalid_i = 1'b1;
    mem_if.mem_rdata_i  = 64'h0BAD;
    #1;
    check("err_no_rvalid", 64'(port_if.rvalid_o), 64'd0);
    check("err_rdata", port_if.rdata_o, 64'h0BAD);
    tick();
    mem_if.mem_rvalid_i = 1'b0;
    #1;
    check("err_set", 64'(err_o), 64'd1);
    tick();
    tick();
    check("err_sticky", 64'(err_o), 64'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    check("err_cleared", 64'(err_o), 64'd0);

    // Reset abandons HOLD; a late response then flags an error
    port_if.req_i = 3'b001;
    #1;
    check("mid_hold_req", 64'(mem_if.mem_req_o), 64'd1);
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    drive_idle();
    #1;
    check("mid_hold_dropped", 64'(mem_if.mem_req_o), 64'd0);
    mem_if.mem_rvalid_i = 1'b1;
    #1;
    check("mid_late_rvalid", 64'(port_if.rvalid_o), 64'd0);
    tick();
    mem_if.mem_rvalid_i = 1'b0;
    #1;
    check("mid_late_err", 64'(err_o), 64'd1);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
